// File: rtl/dfe_capture_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : dfe_capture_buffer_if
//  Description : Bus bundle for the DFE output capture buffer. It groups the
//                capture-side strobe/data, the control inputs (arm/stop), the
//                valid/ready readout stream and the status outputs
//                (count/busy/done).
//  Modports    : slave  - capture buffer view (cap_*, arm, stop and rd_ready
//                         are inputs; rd_*, count, busy and done are outputs)
//                master - driver/consumer view (mirror of slave)
//  Options     : DFE_CAPTURE_SAT_EN adds cap_sat and rd_sat
//  Revision    : 1.0 - initial release
// ============================================================================
interface dfe_capture_buffer_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 11
) ();
  logic              cap_valid;
  logic [DATA_W-1:0] cap_data;
  logic              arm;
  logic              stop;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;
`ifdef DFE_CAPTURE_SAT_EN
  logic              cap_sat;
  logic              rd_sat;
`endif

  modport slave (
    input  cap_valid, cap_data, arm, stop, rd_ready,
`ifdef DFE_CAPTURE_SAT_EN
    input  cap_sat,
    output rd_sat,
`endif
    output rd_valid, rd_data, rd_last, count, busy, done
  );

  modport master (
    output cap_valid, cap_data, arm, stop, rd_ready,
`ifdef DFE_CAPTURE_SAT_EN
    output cap_sat,
    input  rd_sat,
`endif
    input  rd_valid, rd_data, rd_last, count, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/dfe_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dfe_capture_buffer
//  Description : Records signed samples leaving the DFE chain into on-chip
//                RAM once armed, then streams them back in capture order over
//                a valid/ready port with rd_last on the final beat.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - dfe_capture_buffer_if.slave (capture, control,
//                       readout stream and status signals)
//  Options     : DFE_CAPTURE_SAT_EN - stores a saturation flag with every
//                sample (cap_sat) and returns it alongside rd_data (rd_sat)
//  Revision    : 1.0 - initial release
// ============================================================================
module dfe_capture_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  wire                  clk,
  input  wire                  rst,
  dfe_capture_buffer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
`ifdef DFE_CAPTURE_SAT_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_READOUT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   rd_addr_q, rd_addr_d;
  // Middle stage: RAM output register plus its valid/last tags.
  logic               mid_vld_q, mid_vld_d;
  logic               mid_last_q, mid_last_d;
  // Output stage: the registers the consumer sees.
  logic               rd_valid_q, rd_valid_d;
  logic               rd_last_q, rd_last_d;
  logic [RAM_W-1:0]   rd_word_q, rd_word_d;

  logic [RAM_W-1:0]   mem [DEPTH];
  logic [RAM_W-1:0]   ram_q;
  logic [RAM_W-1:0]   wr_word;
  logic               wr_en;
  logic               rd_issue;
  logic               out_free;

`ifdef DFE_CAPTURE_SAT_EN
  assign wr_word    = {bus.cap_sat, bus.cap_data};
  assign bus.rd_sat = rd_word_q[DATA_W];
`else
  assign wr_word    = bus.cap_data;
`endif

  assign bus.rd_data  = rd_word_q[DATA_W-1:0];
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.count    = count_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q != S_IDLE);

  // Output stage can accept a new word when empty or being drained now.
  assign out_free = !rd_valid_q || bus.rd_ready;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    done_d     = 1'b0;
    rd_addr_d  = rd_addr_q;
    mid_vld_d  = mid_vld_q;
    mid_last_d = mid_last_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_word_d  = rd_word_q;
    wr_en      = 1'b0;
    rd_issue   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.arm) begin
          state_d = S_CAPTURE;
          count_d = '0;
        end
      end

      S_CAPTURE: begin
        // count never reaches DEPTH while still in CAPTURE, so every
        // accepted strobe has a free RAM slot.
        if (bus.cap_valid) begin
          wr_en   = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
        if ((bus.cap_valid && (count_q == CNT_W'(DEPTH - 1))) ||
            (bus.stop && (bus.cap_valid || (count_q != '0)))) begin
          state_d    = S_READOUT;
          rd_addr_d  = '0;
          mid_vld_d  = 1'b0;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end else if (bus.stop) begin
          // Empty capture: nothing to stream, finish immediately.
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      S_READOUT: begin
        // Read ahead whenever the middle stage is empty or will move on
        // this cycle, keeping the stream bubble-free under rd_ready=1.
        rd_issue = (!mid_vld_q || out_free) && (rd_addr_q < count_q);

        if (out_free) begin
          rd_valid_d = mid_vld_q;
          rd_last_d  = mid_vld_q && mid_last_q;
          if (mid_vld_q) begin
            rd_word_d = ram_q;
          end
        end

        if (rd_issue) begin
          rd_addr_d  = rd_addr_q + CNT_W'(1);
          mid_vld_d  = 1'b1;
          mid_last_d = (rd_addr_q == (count_q - CNT_W'(1)));
        end else if (out_free) begin
          mid_vld_d = 1'b0;
        end

        if (rd_valid_q && bus.rd_ready && rd_last_q) begin
          state_d    = S_IDLE;
          done_d     = 1'b1;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          mid_vld_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      done_q     <= 1'b0;
      rd_addr_q  <= '0;
      mid_vld_q  <= 1'b0;
      mid_last_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_word_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      done_q     <= done_d;
      rd_addr_q  <= rd_addr_d;
      mid_vld_q  <= mid_vld_d;
      mid_last_q <= mid_last_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_word_q  <= rd_word_d;
    end
  end

  // Capture RAM: one write port, one synchronous read port. The read
  // register only updates on an issued read, so it holds during stalls.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count_q[AW-1:0]] <= wr_word;
    end
    if (rd_issue) begin
      ram_q <= mem[rd_addr_q[AW-1:0]];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dfe_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dfe_capture_buffer
//  Description : Self-checking bench for dfe_capture_buffer (DEPTH=8).
//                Expected beats are queued as samples are driven and popped
//                when the readout port transfers a beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dfe_capture_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;

  dfe_capture_buffer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  dfe_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int errors    = 0;
  int beats     = 0;

  // {last, sat, data}
  logic [DATA_W+1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d, input logic sat, input logic last);
    exp_q.push_back({last, sat, d});
  endtask

  task automatic drive_sample(input logic [DATA_W-1:0] d, input logic sat);
    bus.cap_valid = 1'b1;
    bus.cap_data  = d;
`ifdef DFE_CAPTURE_SAT_EN
    bus.cap_sat   = sat;
`else
    if (sat) begin end
`endif
    tick();
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic do_stop();
    bus.cap_valid = 1'b0;
    bus.stop      = 1'b1;
    tick();
    bus.stop      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int seen = 0;
    for (int c = 0; c < budget; c++) begin
      if (bus.done) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk(tag, 32'(seen), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_qempty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Readout monitor: scoreboard pop on transfer, stability check on stall.
  logic              stall_pend = 1'b0;
  logic [DATA_W+1:0] held_beat;

  always @(negedge clk) begin
    logic [DATA_W+1:0] obs_beat;
    logic              sat_bit;
    logic [DATA_W+1:0] e;
`ifdef DFE_CAPTURE_SAT_EN
    sat_bit = bus.rd_sat;
`else
    sat_bit = 1'b0;
`endif
    obs_beat = {bus.rd_last, sat_bit, bus.rd_data};
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("stall_valid", 32'(bus.rd_valid), 32'd1);
        chk("stall_beat", 32'(obs_beat), 32'(held_beat));
      end
      stall_pend = bus.rd_valid && !bus.rd_ready;
      held_beat  = obs_beat;
      if (bus.rd_valid && bus.rd_ready) begin
        chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(bus.rd_data), 32'(e[DATA_W-1:0]));
          chk("beat_last", 32'(bus.rd_last), 32'(e[DATA_W+1]));
`ifdef DFE_CAPTURE_SAT_EN
          chk("beat_sat", 32'(bus.rd_sat), 32'(e[DATA_W]));
`endif
        end
        beats++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1 [5];
    logic [3:0] pat;
    int base;
    int seen;

    rst           = 1'b1;
    bus.cap_valid = 1'b0;
    bus.cap_data  = '0;
    bus.arm       = 1'b0;
    bus.stop      = 1'b0;
    bus.rd_ready  = 1'b0;
`ifdef DFE_CAPTURE_SAT_EN
    bus.cap_sat   = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_last",  32'(bus.rd_last),  32'd0);
    chk("rst_rd_data",  32'(bus.rd_data),  32'd0);
    chk("rst_count",    32'(bus.count),    32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_done",     32'(bus.done),     32'd0);

    // Samples and stop in IDLE are ignored
    drive_sample(8'h33, 1'b0);
    bus.cap_valid = 1'b0;
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("idle_ignore_count", 32'(bus.count), 32'd0);
    chk("idle_ignore_busy",  32'(bus.busy),  32'd0);

    // Test 1: five samples, stop, exact readout timing
    t1[0] = 8'sd1; t1[1] = 8'hFF; t1[2] = 8'sd127; t1[3] = 8'h80; t1[4] = 8'sd0;
    bus.rd_ready = 1'b1;
    do_arm();
    chk("t1_busy_after_arm", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      push_exp(t1[i], 1'b0, i == 4);
      drive_sample(t1[i], 1'b0);
    end
    do_stop();
    chk("t1_count", 32'(bus.count), 32'd5);
    chk("t1_valid_e0", 32'(bus.rd_valid), 32'd0);
    tick();
    chk("t1_valid_e1", 32'(bus.rd_valid), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t1_valid_stream", 32'(bus.rd_valid), 32'd1);
      chk("t1_last_pos", 32'(bus.rd_last), 32'(i == 4));
      tick();
    end
    chk("t1_done", 32'(bus.done), 32'd1);
    chk("t1_busy_off", 32'(bus.busy), 32'd0);
    chk("t1_valid_off", 32'(bus.rd_valid), 32'd0);
    chk("t1_qempty", 32'(exp_q.size()), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(bus.done), 32'd0);
    chk("t1_count_hold", 32'(bus.count), 32'd5);

    // Test 2: overfill, auto readout after DEPTH samples
    do_arm();
    for (int i = 0; i < 12; i++) begin
      if (i < DEPTH) push_exp(8'(i), 1'b0, i == DEPTH - 1);
      drive_sample(8'(i), 1'b0);
    end
    bus.cap_valid = 1'b0;
    chk("t2_count_full", 32'(bus.count), 32'd8);
    wait_done("t2_done", 40);
    chk("t2_count_hold", 32'(bus.count), 32'd8);
    tick();

    // Test 3: rd_ready toggling 1,0,0,1
    do_arm();
    for (int i = 0; i < 6; i++) begin
      push_exp(8'h50 + 8'(i), 1'b0, i == 5);
      drive_sample(8'h50 + 8'(i), 1'b0);
    end
    do_stop();
    pat = 4'b1001;
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      bus.rd_ready = pat[c % 4];
      if (bus.done) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("t3_done", 32'(seen), 32'd1);
    chk("t3_qempty", 32'(exp_q.size()), 32'd0);
    bus.rd_ready = 1'b1;
    tick();

    // Test 4: arm then immediate stop
    do_arm();
    do_stop();
    chk("t4_done", 32'(bus.done), 32'd1);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_count", 32'(bus.count), 32'd0);
    chk("t4_valid", 32'(bus.rd_valid), 32'd0);
    tick();
    chk("t4_done_pulse", 32'(bus.done), 32'd0);
    chk("t4_valid2", 32'(bus.rd_valid), 32'd0);

    // Test 5: reset during the third readout beat, then fresh capture
    do_arm();
    for (int i = 0; i < 5; i++) begin
      push_exp(8'hA0 + 8'(i), 1'b0, i == 4);
      drive_sample(8'hA0 + 8'(i), 1'b0);
    end
    base = beats;
    do_stop();
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.rd_valid && (beats - base == 2)) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("t5_third_beat", 32'(seen), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("t5_rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("t5_rst_busy",  32'(bus.busy),     32'd0);
    chk("t5_rst_count", 32'(bus.count),    32'd0);
    do_arm();
    push_exp(8'h11, 1'b0, 1'b0);
    drive_sample(8'h11, 1'b0);
    push_exp(8'hEE, 1'b0, 1'b1);
    drive_sample(8'hEE, 1'b0);
    do_stop();
    chk("t5_count", 32'(bus.count), 32'd2);
    wait_done("t5_done", 20);
    tick();

    // Test 6: saturation flag carried with samples (checked when enabled)
    do_arm();
    push_exp(8'd10, 1'b0, 1'b0);
    drive_sample(8'd10, 1'b0);
    push_exp(8'd20, 1'b1, 1'b0);
    drive_sample(8'd20, 1'b1);
    push_exp(8'd30, 1'b0, 1'b1);
    drive_sample(8'd30, 1'b0);
    do_stop();
    chk("t6_count", 32'(bus.count), 32'd3);
    wait_done("t6_done", 20);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dfe_capture_buffer.md
# dfe_capture_buffer

Output-side capture buffer for the DFE filter chain. It records the 8-bit signed samples leaving the chain output (`top_chain_out` qualified by `valid_out`) into on-chip RAM once armed. It then streams them back in capture order over a valid/ready port for readback and golden-file comparison. It is the sink counterpart of the stimulus memory that feeds the chain input.

## Interface
Parameters:
- `DATA_W`, 8, sample width (signed two's complement)
- `DEPTH`, 1024, capture RAM depth in samples (power of two, ≥ 4)
- `CNT_W`, $clog2(DEPTH)+1, width of the sample counter

Ports:
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `cap_valid`  in  1  sample strobe from chain `valid_out`
- `cap_data`  in  DATA_W  sample from chain `top_chain_out`
- `arm`  in  1  start a capture (sampled in IDLE only)
- `stop`  in  1  end capture early and begin readout
- `rd_valid`  out  1  readout beat valid
- `rd_ready`  in  1  readout consumer ready
- `rd_data`  out  DATA_W  readout sample
- `rd_last`  out  1  high with final readout beat
- `count`  out  CNT_W  samples captured in current/last capture
- `busy`  out  1  high in CAPTURE or READOUT
- `done`  out  1  one-cycle pulse when readout completes

## Operation
- States: IDLE, CAPTURE, READOUT.
- IDLE: `arm`=1 → CAPTURE; `count` cleared to 0 on that edge. `stop`, `cap_valid` ignored.
- CAPTURE: each cycle with `cap_valid`=1 writes `cap_data` to RAM[count] and increments `count`.
- CAPTURE → READOUT when `count` reaches DEPTH (the write making it DEPTH is the last), or when `stop`=1.
- `stop` and `cap_valid` in the same cycle: the sample is written, then the state is READOUT.
- `stop` with `count`=0 (including a same-cycle `cap_valid`=0): → IDLE directly, `done` pulses, no beats.
- Samples with `cap_valid`=1 after full are dropped; `count` saturates at DEPTH, never wraps.
- READOUT: emits RAM[0..count-1] in order. A beat transfers when `rd_valid` & `rd_ready`. `rd_data`, `rd_valid` hold stable while `rd_valid`=1 and `rd_ready`=0.
- `rd_last`=1 only on beat index count-1. After that transfer → IDLE and `done`=1 for one cycle.
- `arm` in CAPTURE/READOUT is ignored. `cap_valid` in READOUT/IDLE is ignored; the RAM is not written.
- `count` holds its final value in IDLE until the next `arm`.

## Timing
- Reset values: state IDLE, `rd_valid`=0, `rd_last`=0, `rd_data`=0, `count`=0, `busy`=0, `done`=0.
- Reset mid-capture or mid-readout returns to IDLE next edge. RAM contents are not cleared and are don't-care.
- Capture: zero-bubble; one sample accepted per cycle on consecutive `cap_valid`.
- `busy` rises the cycle after `arm` is sampled and falls with the `done` pulse.
- RAM read is synchronous (1-cycle). First `rd_valid` appears exactly 2 cycles after the READOUT entry edge.
- With `rd_ready` held 1, beats transfer every cycle with no bubbles; RAM read-ahead is required.
- Dropping `rd_ready` for N cycles stalls the stream N cycles with no loss or duplication.
- `done` is asserted the cycle after the `rd_last` transfer.

## Configuration
- `DFE_CAPTURE_SAT_EN` defined: adds input `cap_sat` (1 bit, OR of chain overflow/underflow flags) and output `rd_sat` (1 bit).
  - `cap_sat` is stored alongside each sample (RAM word DATA_W+1 bits).
  - `rd_sat` follows the same timing and handshake as `rd_data`; reset value 0.
- Not defined: the ports are absent and the RAM word is DATA_W bits.

## Test plan
- Reset, `arm`, then 5 consecutive `cap_valid` with data 1,−1,127,−128,0, then `stop`, `rd_ready`=1 → `count`=5. First `rd_valid` 2 cycles after READOUT entry. Beats 1,−1,127,−128,0 on consecutive cycles, `rd_last` on 0, `done` the next cycle.
- DEPTH=8, 12 consecutive samples 0..11 → auto READOUT after 8, `count`=8, beats 0..7, samples 8..11 dropped.
- Readout with `rd_ready` toggling 1,0,0,1 pattern → every beat delivered once in order, `rd_data` stable during stalls.
- `arm` then immediate `stop` (no samples) → IDLE, `done` pulse, `rd_valid` never asserted, `count`=0.
- `rst` asserted on the third readout beat → next cycle `rd_valid`=0, `busy`=0, `count`=0. A fresh `arm` and 2 samples read back correctly.
- With `DFE_CAPTURE_SAT_EN`, samples 10,20,30 with `cap_sat`=0,1,0 → `rd_sat` 0,1,0 aligned with beats.
